// File: rtl/count_sched_pkg.sv
// ============================================================================
//  Module   : count_sched_pkg
//  Purpose  : Shared types and constants for the count_sched interval scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_sched_pkg;

    localparam int CNT_WIDTH_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    typedef logic req_idx_t;

    // Sole requester wins; on contention the one not served last wins.
    function automatic req_idx_t pick_winner(input logic [1:0] req, input req_idx_t last);
        req_idx_t w;
        if (req == 2'b11) begin
            w = ~last;
        end else begin
            w = req[1];
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/count_core.sv
// ============================================================================
//  Module   : count_core
//  Purpose  : WIDTH-bit up-counter with synchronous clear/enable and a
//             terminal-count compare against an externally held limit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_core
    import count_sched_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= q_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign q  = q_q;
    assign tc = (q_q == limit);

endmodule

`default_nettype wire

// File: rtl/count_sched.sv
// ============================================================================
//  Module   : count_sched
//  Purpose  : Round-robin scheduler granting a shared interval counter to one
//             of two requesters. Optional pause input under `CNT_PAUSE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_sched
    import count_sched_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             rstn,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
`ifdef CNT_PAUSE_EN
    input  logic             pause,
`endif
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] COUNT
);

    state_t           state_q, state_d;
    req_idx_t         win_q, win_d;
    req_idx_t         last_q, last_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             clr, en, tc, hold;

`ifdef CNT_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .CLK   (CLK),
        .rstn  (rstn),
        .clr   (clr),
        .en    (en),
        .limit (limit_q),
        .q     (COUNT),
        .tc    (tc)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        limit_d = limit_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        clr     = 1'b0;
        en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    win_d   = pick_winner(req, last_q);
                    limit_d = win_d ? len1 : len0;
                    gnt_d   = win_d ? 2'b10 : 2'b01;
                    clr     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Abort outranks terminal count and pause.
                if (!req[win_q]) begin
                    gnt_d   = 2'b00;
                    clr     = 1'b1;
                    state_d = IDLE;
                end else if (!hold) begin
                    if (tc) begin
                        done_d[win_q] = 1'b1;
                        gnt_d         = 2'b00;
                        last_d        = win_q;
                        state_d       = DONE;
                    end else begin
                        en = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset leaves last_q = 1 so requester 0 wins the first contention.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            limit_q <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            limit_q <= limit_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q == RUN) || (state_q == DONE);

endmodule

`default_nettype wire
